uart_rx: RTL and testbench

- 8N1 UART receiver for the USB-serial input line (`usb_rx`) on the Cu board.
- Recovers bytes using a mid-bit sampling bit timer.
- Presents each byte on a valid/ready output register to downstream logic (command parser, LED/segment control).
- Flags framing errors and overruns as one-cycle pulses.

---
 rtl/uart_pkg.sv | 16 +
 rtl/bit_sync.sv | 31 +++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM encoding and bit-rate helper
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - generic two-flop synchronizer with selectable reset value
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and valid/ready output register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic rx_s;

    bit_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    logic             rx_s_d_q,    rx_s_d_d;
    logic [1:0]       settle_q,    settle_d;
    logic             armed_q,     armed_d;
    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] timer_q,     timer_d;
    logic [IDX_W-1:0] bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic             tick;
    logic             deliver;

    always_comb begin
        rx_s_d_d    = rx_s;
        settle_d    = {settle_q[0], 1'b1};
        // A line already low when reset releases must rise before a start edge counts.
        armed_d     = armed_q | (settle_q[1] & rx_s);
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
        tick        = (timer_q == '0);

        if (state_q != ST_IDLE && !tick) begin
            timer_d = timer_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (armed_q && rx_s_d_q && !rx_s) begin
                    state_d = ST_START;
                    timer_d = HALF_LOAD;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        timer_d   = FULL_LOAD;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    timer_d   = FULL_LOAD;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A held byte being consumed this cycle frees the register for the new one.
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s_d_q    <= 1'b1;
            settle_q    <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_s_d_q    <= rx_s_d_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;

    localparam int C   = 10;
    localparam int LAT = 2 + C / 2 + 9 * C + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLK_HZ(1000000), .BAUD(100000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit         line_q[$];
    bit         rdy_q[$];
    bit         rst_q[$];
    int         ev_at[$];
    logic [7:0] ev_byte[$];
    bit         ev_ok[$];
    int         bz_at[$];
    bit         bz_val[$];

    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_fe    = 1'b0;
    logic       exp_ov    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input bit l, input int rmode, input bit r);
        line_q.push_back(l);
        rdy_q.push_back(rmode == 2 ? bit'($urandom_range(0, 3) != 0) : bit'(rmode));
        rst_q.push_back(r);
    endtask

    task automatic add_level(input bit l, input int n, input int rmode);
        for (int i = 0; i < n; i++) push(l, rmode, 1'b0);
    endtask

    task automatic add_frame(input logic [7:0] b, input bit stop_ok, input int rmode);
        int t0;
        t0 = line_q.size();
        add_level(1'b0, C, rmode);
        for (int i = 0; i < 8; i++) add_level(b[i], C, rmode);
        add_level(stop_ok, C, rmode);
        ev_at.push_back(t0 + LAT);
        ev_byte.push_back(b);
        ev_ok.push_back(stop_ok);
    endtask

    task automatic run_stream();
        int  ei;
        int  bi;
        bit  r;
        ei = 0;
        bi = 0;
        for (int k = 0; k < line_q.size(); k++) begin
            @(posedge clk);
            if (k > 0) begin
                exp_fe = 1'b0;
                exp_ov = 1'b0;
                if (rst_q[k-1]) begin
                    exp_valid = 1'b0;
                    exp_data  = 8'h00;
                end else begin
                    r = rdy_q[k-1];
                    if (ei < ev_at.size() && ev_at[ei] == k) begin
                        if (!ev_ok[ei]) begin
                            exp_fe = 1'b1;
                        end else if (!exp_valid || r) begin
                            exp_data  = ev_byte[ei];
                            exp_valid = 1'b1;
                        end else begin
                            exp_ov = 1'b1;
                        end
                        ei++;
                    end else if (exp_valid && r) begin
                        exp_valid = 1'b0;
                    end
                end
            end
            #1;
            chk("valid", 32'(valid), 32'(exp_valid));
            chk("data", 32'(data), 32'(exp_data));
            chk("frame_err", 32'(frame_err), 32'(exp_fe));
            chk("overrun", 32'(overrun), 32'(exp_ov));
            while (bi < bz_at.size() && bz_at[bi] == k) begin
                chk("busy", 32'(busy), 32'(bz_val[bi]));
                bi++;
            end
            rx    = line_q[k];
            ready = rdy_q[k];
            rst_n = !rst_q[k];
            if (rst_q[k] && !(k > 0 && rst_q[k-1])) begin
                #1;
                chk("async_rst_valid", 32'(valid), 32'd0);
                chk("async_rst_data", 32'(data), 32'd0);
                chk("async_rst_fe", 32'(frame_err), 32'd0);
                chk("async_rst_ov", 32'(overrun), 32'd0);
                chk("async_rst_busy", 32'(busy), 32'd0);
            end
        end
        chk("events_consumed", 32'(ei), 32'(ev_at.size()));
    endtask

    initial begin
        int t;
        logic [7:0] b;
        bit ok;
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_fe", 32'(frame_err), 32'd0);
        chk("reset_ov", 32'(overrun), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        add_level(1'b1, 20, 1);
        add_frame(8'hA5, 1'b1, 1);
        add_level(1'b1, 5, 1);

        add_frame(8'h00, 1'b1, 1);
        add_frame(8'hFF, 1'b1, 1);
        add_level(1'b1, 5, 1);

        add_frame(8'h3C, 1'b0, 1);
        add_level(1'b0, 50, 1);
        add_level(1'b1, 10, 1);
        add_frame(8'h55, 1'b1, 1);
        add_level(1'b1, 5, 1);

        t = line_q.size();
        add_level(1'b0, 3, 1);
        add_level(1'b1, 20, 1);
        bz_at.push_back(t + 3);         bz_val.push_back(1'b1);
        bz_at.push_back(t + 2 + C / 2); bz_val.push_back(1'b1);
        bz_at.push_back(t + 4 + C / 2); bz_val.push_back(1'b0);

        add_frame(8'h11, 1'b1, 0);
        add_frame(8'h22, 1'b1, 0);
        add_level(1'b1, 3, 0);
        add_level(1'b1, 1, 1);
        add_level(1'b1, 5, 0);
        add_level(1'b1, 5, 1);

        for (int i = 0; i < 25; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            add_frame(b, ok, 2);
            add_level(1'b1, ok ? $urandom_range(0, 4) : $urandom_range(1, 4), 2);
        end
        add_level(1'b1, 10, 1);

        add_frame(8'hC3, 1'b1, 0);
        add_level(1'b1, 3, 0);
        add_level(1'b0, C, 0);
        add_level(1'b1, C, 0);
        add_level(1'b0, 3 * C + 2, 0);
        for (int i = 0; i < 3; i++) push(1'b0, 0, 1'b1);
        add_level(1'b0, C - 5 + 2 * C, 0);
        add_level(1'b1, 2 * C, 0);
        add_level(1'b1, 10, 1);
        add_frame(8'h7E, 1'b1, 1);
        add_level(1'b1, 10, 1);
        bz_at.push_back(line_q.size() - 1); bz_val.push_back(1'b0);

        run_stream();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
